ucie_ctl_sb_tx_scheduler: RTL and testbench

Sideband transmit scheduler between the UCIe adapter control FSM and the PHY sideband interface. Buffers adapter sideband message requests (e_SB_msg encodings) from the CNTL FSM in a small FIFO and drains them to the PHY with a valid/ready handshake. Tracks the single outstanding request (REQ_ACTIVE / REQ_LINKRESET) and flags a response timeout, which the CNTL FSM maps to LINKERROR.

---
 rtl/ucie_ctl_sb_tx_scheduler.sv | 160 ++++++++++++++++
 tb/tb_ucie_ctl_sb_tx_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_tx_scheduler.sv
// UCIe adapter sideband TX scheduler: message FIFO toward the PHY plus outstanding-request tracking.
// Response tracking and timeout are compiled only when UCIE_CTL_SB_TIMEOUT_EN is defined.
module ucie_ctl_sb_tx_scheduler #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_msg_valid,
    input  logic [4:0]                    i_msg,
    output logic                          o_msg_ready,
    output logic                          o_illegal_msg,
    output logic                          o_sb_valid,
    output logic [4:0]                    o_sb_msg,
    input  logic                          i_sb_ready,
    input  logic                          i_rx_rsp_active,
    input  logic                          i_rx_rsp_linkreset,
    output logic                          o_pending_rsp,
    output logic                          o_timeout,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [4:0] MSG_NOP           = 5'b00000;
    localparam logic [4:0] MSG_REQ_ACTIVE    = 5'b10101;
    localparam logic [4:0] MSG_RSP_ACTIVE    = 5'b11001;
    localparam logic [4:0] MSG_REQ_LINKRESET = 5'b10111;
    localparam logic [4:0] MSG_RSP_LINKRESET = 5'b11011;

    logic [4:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_illegal;

    logic w_full;
    logic w_empty;
    logic w_legal;
    logic w_accept;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_legal = 1'b0;
        case (i_msg)
            MSG_NOP, MSG_REQ_ACTIVE, MSG_RSP_ACTIVE,
            MSG_REQ_LINKRESET, MSG_RSP_LINKRESET: w_legal = 1'b1;
            default:                              w_legal = 1'b0;
        endcase
    end

    assign o_msg_ready = !w_full && !i_flush;
    assign w_accept    = i_msg_valid && o_msg_ready;
    assign w_push      = w_accept && w_legal;
    assign o_sb_valid  = !w_empty;
    // Gate the head so the bus reads zero while empty (memory itself is not reset).
    assign o_sb_msg    = w_empty ? 5'b00000 : r_mem[r_rptr];
    assign w_pop       = o_sb_valid && i_sb_ready;

    assign o_count       = r_count;
    assign o_illegal_msg = r_illegal;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_msg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
            if (i_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifdef UCIE_CTL_SB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Timer value in the last cycle before expiry; the pulse lands one cycle later.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 2);

    logic          r_pending;
    logic          r_exp_linkreset;
    logic          r_timeout;
    logic [TW-1:0] r_timer;

    logic w_req_pop;
    logic w_match;

    assign w_req_pop = w_pop && !i_flush &&
                       ((o_sb_msg == MSG_REQ_ACTIVE) || (o_sb_msg == MSG_REQ_LINKRESET));
    assign w_match   = r_exp_linkreset ? i_rx_rsp_linkreset : i_rx_rsp_active;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending       <= 1'b0;
            r_exp_linkreset <= 1'b0;
            r_timeout       <= 1'b0;
            r_timer         <= '0;
        end else begin
            r_timeout <= 1'b0;
            if (i_flush) begin
                r_pending <= 1'b0;
                r_timer   <= '0;
            end else if (w_req_pop) begin
                // A fresh request supersedes any response arriving for the previous one.
                r_pending       <= 1'b1;
                r_exp_linkreset <= (o_sb_msg == MSG_REQ_LINKRESET);
                r_timer         <= '0;
            end else if (r_pending) begin
                if (w_match) begin
                    r_pending <= 1'b0;
                    r_timer   <= '0;
                end else if (r_timer == TIMER_LAST) begin
                    r_timeout <= 1'b1;
                    r_pending <= 1'b0;
                    r_timer   <= '0;
                end else begin
                    r_timer <= r_timer + TW'(1);
                end
            end
        end
    end

    assign o_pending_rsp = r_pending;
    assign o_timeout     = r_timeout;
`else
    logic w_unused_rsp;
    assign w_unused_rsp  = i_rx_rsp_active ^ i_rx_rsp_linkreset;
    assign o_pending_rsp = 1'b0;
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ucie_ctl_sb_tx_scheduler.sv
// Directed self-checking bench for ucie_ctl_sb_tx_scheduler (FIFO_DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ucie_ctl_sb_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       msg_valid;
    logic [4:0] msg;
    logic       msg_ready;
    logic       illegal;
    logic       sb_valid;
    logic [4:0] sb_msg;
    logic       sb_ready;
    logic       rsp_active;
    logic       rsp_linkreset;
    logic       pending;
    logic       timeout;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

`ifdef UCIE_CTL_SB_TIMEOUT_EN
    localparam logic TRK = 1'b1;
`else
    localparam logic TRK = 1'b0;
`endif

    always #5 clk = ~clk;

    ucie_ctl_sb_tx_scheduler #(
        .FIFO_DEPTH    (4),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush           (flush),
        .i_msg_valid       (msg_valid),
        .i_msg             (msg),
        .o_msg_ready       (msg_ready),
        .o_illegal_msg     (illegal),
        .o_sb_valid        (sb_valid),
        .o_sb_msg          (sb_msg),
        .i_sb_ready        (sb_ready),
        .i_rx_rsp_active   (rsp_active),
        .i_rx_rsp_linkreset(rsp_linkreset),
        .o_pending_rsp     (pending),
        .o_timeout         (timeout),
        .o_count           (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; msg_valid = 1'b0; msg = 5'b0;
        sb_ready = 1'b0; rsp_active = 1'b0; rsp_linkreset = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(msg_ready), 1);
        chk("rst_sbvalid", 32'(sb_valid), 0);
        chk("rst_sbmsg", 32'(sb_msg), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_illegal", 32'(illegal), 0);

        // Single REQ_ACTIVE passes straight through and becomes outstanding.
        sb_ready = 1'b1; msg_valid = 1'b1; msg = 5'b10101;
        tick();
        msg_valid = 1'b0;
        chk("req_sbvalid", 32'(sb_valid), 1);
        chk("req_sbmsg", 32'(sb_msg), 32'h15);
        chk("req_count", 32'(count), 1);
        tick();
        chk("req_popped", 32'(count), 0);
        chk("req_pending", 32'(pending), 32'(TRK));
        rsp_active = 1'b1;
        tick();
        rsp_active = 1'b0;
        chk("rsp_cleared", 32'(pending), 0);
        chk("rsp_notimeout", 32'(timeout), 0);

        // Illegal encoding is dropped with a one-cycle flag.
        msg_valid = 1'b1; msg = 5'b01010;
        tick();
        msg_valid = 1'b0;
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_count", 32'(count), 0);
        tick();
        chk("ill_clear", 32'(illegal), 0);

        // Fill while the PHY stalls, then drain in push order.
        sb_ready = 1'b0; msg_valid = 1'b1;
        msg = 5'b10101; tick();
        msg = 5'b10111; tick();
        msg = 5'b11001; tick();
        msg = 5'b11011; tick();
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(msg_ready), 0);
        msg = 5'b00000; tick();
        chk("full_held", 32'(count), 4);
        chk("full_head", 32'(sb_msg), 32'h15);
        msg_valid = 1'b0; sb_ready = 1'b1;
        chk("drain0", 32'(sb_msg), 32'h15); tick();
        chk("drain1", 32'(sb_msg), 32'h17); tick();
        chk("drain2", 32'(sb_msg), 32'h19); tick();
        chk("drain3", 32'(sb_msg), 32'h1b); tick();
        chk("drain_count", 32'(count), 0);
        chk("drain_sbvalid", 32'(sb_valid), 0);
        chk("drain_pending", 32'(pending), 32'(TRK));
        flush = 1'b1; tick(); flush = 1'b0;
        chk("drain_flushed", 32'(pending), 0);

        // REQ_LINKRESET with no response times out exactly at pop+16.
        msg_valid = 1'b1; msg = 5'b10111;
        tick();
        msg_valid = 1'b0;
        tick();
        chk("to_pending", 32'(pending), 32'(TRK));
        repeat (14) tick();
        chk("to_pend15", 32'(pending), 32'(TRK));
        chk("to_early", 32'(timeout), 0);
        tick();
        chk("to_pulse", 32'(timeout), 32'(TRK));
        chk("to_pend16", 32'(pending), 0);
        tick();
        chk("to_oneshot", 32'(timeout), 0);

        // Matching response in the expiring cycle wins.
        msg_valid = 1'b1; msg = 5'b10111;
        tick();
        msg_valid = 1'b0;
        repeat (15) tick();
        rsp_linkreset = 1'b1;
        tick();
        rsp_linkreset = 1'b0;
        chk("late_rsp_noto", 32'(timeout), 0);
        chk("late_rsp_pend", 32'(pending), 0);
        tick();
        chk("late_rsp_noto2", 32'(timeout), 0);

        // Non-matching response is ignored.
        msg_valid = 1'b1; msg = 5'b10101;
        tick();
        msg_valid = 1'b0;
        tick();
        rsp_linkreset = 1'b1;
        tick();
        rsp_linkreset = 1'b0;
        chk("mismatch_pend", 32'(pending), 32'(TRK));

        // Flush with queued entries, pending request and a concurrent push.
        sb_ready = 1'b0; msg_valid = 1'b1;
        msg = 5'b00000; tick();
        msg = 5'b10101; tick();
        chk("fl_count2", 32'(count), 2);
        chk("fl_pending", 32'(pending), 32'(TRK));
        flush = 1'b1; msg = 5'b11001;
        #1;
        chk("fl_ready", 32'(msg_ready), 0);
        tick();
        flush = 1'b0; msg_valid = 1'b0;
        chk("fl_count", 32'(count), 0);
        chk("fl_sbvalid", 32'(sb_valid), 0);
        chk("fl_pend", 32'(pending), 0);
        chk("fl_sbmsg", 32'(sb_msg), 0);
        tick();
        chk("fl_lost", 32'(count), 0);

        // Simultaneous push and pop leaves occupancy unchanged.
        msg_valid = 1'b1; msg = 5'b00000;
        tick();
        chk("pp_count1", 32'(count), 1);
        sb_ready = 1'b1; msg = 5'b11011;
        tick();
        msg_valid = 1'b0;
        chk("pp_count", 32'(count), 1);
        chk("pp_head", 32'(sb_msg), 32'h1b);
        tick();
        chk("pp_empty", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
